// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, 3-sample majority vote, LSB-first deserialiser with parity/stop check.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchroniser on RX_IN (adds 2 CLK of latency).
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge CLK) begin
        if (RST) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX_IN};
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]              samp_q, samp_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    par_flag_q, par_flag_d;
    logic                    stp_flag_q, stp_flag_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
    logic                    dv_q, dv_d;
    logic                    pe_q, pe_d;
    logic                    se_q, se_d;

    logic [PRESCALE_W-1:0]   half, half_m2, half_m1, vote_pt, last_edge;
    logic                    at_vote, bit_end, sampled_bit;

    assign half        = Prescale >> 1;
    assign half_m2     = half - PRESCALE_W'(2);
    assign half_m1     = half - PRESCALE_W'(1);
    assign vote_pt     = half + PRESCALE_W'(1);
    assign last_edge   = Prescale - PRESCALE_W'(1);
    assign at_vote     = (edge_cnt_q == vote_pt);
    assign bit_end     = (edge_cnt_q == last_edge);
    assign sampled_bit = maj3(samp_q);

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_flag_d = par_flag_q;
        stp_flag_d = stp_flag_q;
        pdata_d    = pdata_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (edge_cnt_q == half_m2) samp_d[0] = rx_s;
            if (edge_cnt_q == half_m1) samp_d[1] = rx_s;
            if (edge_cnt_q == half)    samp_d[2] = rx_s;
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s) begin
                    state_d    = START;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                end
            end
            START: begin
                // A start bit that votes high was a line glitch: drop it silently.
                if (at_vote && sampled_bit) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_vote) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (at_vote && (sampled_bit != ((^shift_q) ^ par_typ_q))) par_flag_d = 1'b1;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (at_vote && !sampled_bit) stp_flag_d = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                    pe_d    = par_flag_q;
                    se_d    = stp_flag_q;
                    if (!par_flag_q && !stp_flag_q) begin
                        dv_d    = 1'b1;
                        pdata_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    // Datapath state is fully rewritten before use in every frame.
    always_ff @(posedge CLK) begin
        samp_q    <= samp_d;
        shift_q   <= shift_d;
        par_en_q  <= par_en_d;
        par_typ_q <= par_typ_d;
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, parity/stop errors, start glitch, back-to-back frames, mid-frame reset.
module tb_uart_rx;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
    localparam int ADJ = 2;
`else
    localparam int ADJ = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor: counts high cycles of each pulse output and logs delivered bytes.
    int            dv_cnt = 0;
    int            pe_cnt = 0;
    int            se_cnt = 0;
    int            dv_cyc = 0;
    logic [DW-1:0] dv_log [0:15];
    always @(negedge CLK) begin
        if (data_valid) begin
            dv_log[dv_cnt[3:0]] = P_DATA;
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
        if (par_err) pe_cnt = pe_cnt + 1;
        if (stp_err) se_cnt = se_cnt + 1;
    end

    int tests = 0;
    int fails = 0;
    int start_cyc = 0;
    int dv0, pe0, se0, lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic snap();
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        se0 = se_cnt;
    endtask

    // Called at a negedge; leaves the line at the stop value on the negedge after the last stop position.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit pbit, input bit stop, input bit flip);
        Prescale  = PW'(p);
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        start_cyc = cyc + 1;
        drive_bit(1'b0, p);
        if (flip) begin
            PAR_EN  = ~PAR_EN;
            PAR_TYP = ~PAR_TYP;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stop, p);
    endtask

    initial begin
        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_pdata", P_DATA, 8'h00);
        check("rst_dv", data_valid, 1'b0);
        check("rst_pe", par_err, 1'b0);
        check("rst_se", stp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        RST = 1'b0;
        idle(4);

        // 1: P=8, even parity, 0xA5 (parity 0); config flipped mid-frame must be ignored
        snap();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        lat = dv_cyc - start_cyc;
        check("t1_dv_count", dv_cnt - dv0, 1);
        check("t1_pdata", P_DATA, 8'hA5);
        check("t1_no_pe", pe_cnt - pe0, 0);
        check("t1_no_se", se_cnt - se0, 0);
        check("t1_latency_88pm1", (lat >= 87 + ADJ) && (lat <= 89 + ADJ), 1'b1);

        // 2: P=16, odd parity, 0x3C with wrong parity bit 0
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(8);
        check("t2_pe_count", pe_cnt - pe0, 1);
        check("t2_no_dv", dv_cnt - dv0, 0);
        check("t2_no_se", se_cnt - se0, 0);
        check("t2_pdata_held", P_DATA, 8'hA5);

        // 3: P=8, no parity, 0x81 with stop 0, then a good 0x42
        snap();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        check("t3_se_count", se_cnt - se0, 1);
        check("t3_no_dv", dv_cnt - dv0, 0);
        check("t3_no_pe", pe_cnt - pe0, 0);
        check("t3_idle", busy, 1'b0);
        snap();
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        check("t3_dv_count", dv_cnt - dv0, 1);
        check("t3_pdata", P_DATA, 8'h42);

        // 4: P=16, 3-cycle low glitch then a good 0x55
        snap();
        Prescale = PW'(16);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (7 + ADJ) @(negedge CLK);
        check("t4_busy_before_vote", busy, 1'b1);
        @(negedge CLK);
        check("t4_busy_after_vote", busy, 1'b0);
        idle(20);
        check("t4_no_dv", dv_cnt - dv0, 0);
        check("t4_no_err", (pe_cnt - pe0) + (se_cnt - se0), 0);
        snap();
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        check("t4_dv_count", dv_cnt - dv0, 1);
        check("t4_pdata", P_DATA, 8'h55);

        // 5: P=32, back-to-back 0x00 then 0xFF
        snap();
        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        check("t5_dv_count", dv_cnt - dv0, 2);
        check("t5_first", dv_log[dv0[3:0]], 8'h00);
        check("t5_second", dv_log[(dv0 + 1) & 15], 8'hFF);
        check("t5_no_err", (pe_cnt - pe0) + (se_cnt - se0), 0);

        // 6: reset during data bit 4 of 0x99, then a good 0x66
        snap();
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        check("t6_busy_pre_rst", busy, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_pdata", P_DATA, 8'h00);
        check("t6_rst_pulses", {data_valid, par_err, stp_err}, 3'b000);
        RST = 1'b0;
        idle(40);
        check("t6_no_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        snap();
        send_frame(8'h66, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        check("t6_dv_count", dv_cnt - dv0, 1);
        check("t6_pdata", P_DATA, 8'h66);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
